// File: rtl/span_scheduler_if.sv
// span_scheduler_if: request, engine and status signals of the span scheduler.
// Rev 1.0 -- slave modport is the scheduler's view, master is the environment's view.
`default_nettype none

interface span_scheduler_if #(
   parameter int DEPTH = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic          req_valid;
   logic          req_ready;
   logic [10:0]   req_x0;
   logic [10:0]   req_x1;
   logic [10:0]   req_y;
   logic [10:0]   req_z;
   logic          flush;
   logic          eng_start;
   logic [10:0]   eng_x0;
   logic [10:0]   eng_x1;
   logic [10:0]   eng_y;
   logic [10:0]   eng_z;
   logic          eng_done;
   logic          busy;
   logic [LW-1:0] level;
   logic [15:0]   spans_done;
   logic [15:0]   drop_count;

   modport slave (
      input  req_valid, req_x0, req_x1, req_y, req_z, flush, eng_done,
      output req_ready, eng_start, eng_x0, eng_x1, eng_y, eng_z,
             busy, level, spans_done, drop_count
   );

   modport master (
      output req_valid, req_x0, req_x1, req_y, req_z, flush, eng_done,
      input  req_ready, eng_start, eng_x0, eng_x1, eng_y, eng_z,
             busy, level, spans_done, drop_count
   );
endinterface

`default_nettype wire

// File: rtl/span_scheduler.sv
// span_scheduler: span FIFO plus issue FSM for the single-row span engine.
// Rev 1.0 -- optional screen clipping at enqueue enabled by SPAN_CLIP_EN.
`default_nettype none

module span_scheduler #(
   parameter int DEPTH    = 8,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  wire logic       clk,
   input  wire logic       reset,
   span_scheduler_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("span_scheduler: DEPTH must be a power of 2 and >= 2");
   end
   if (SCREEN_W < 1 || SCREEN_W > 2048 || SCREEN_H < 1 || SCREEN_H > 2048) begin : g_bad_screen
      $error("span_scheduler: screen bounds must fit 11-bit coordinates");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

   state_t        state, state_nxt;
   logic [43:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic [10:0]   eng_x0, eng_x1, eng_y, eng_z;
   logic [15:0]   spans_done;
   logic [10:0]   lo, hi, hi_st;
   logic          keep, accept, push, pop, start, done_hit;

   always_comb begin
      lo = (bus.req_x0 > bus.req_x1) ? bus.req_x1 : bus.req_x0;
      hi = (bus.req_x0 > bus.req_x1) ? bus.req_x0 : bus.req_x1;
   end

`ifdef SPAN_CLIP_EN
   localparam logic [10:0] X_LIM = 11'(SCREEN_W);
   localparam logic [10:0] Y_LIM = 11'(SCREEN_H);
   localparam logic [10:0] X_MAX = 11'(SCREEN_W - 1);
   logic [15:0] drop_count;

   always_comb begin
      keep  = (bus.req_y < Y_LIM) && (lo < X_LIM);
      hi_st = (hi > X_MAX) ? X_MAX : hi;
   end

   // Drops are counted per accepted transfer, independent of flush.
   always_ff @(posedge clk) begin
      if (reset)
         drop_count <= '0;
      else if (accept && !keep && drop_count != 16'hFFFF)
         drop_count <= drop_count + 16'd1;
   end
`else
   logic [15:0] drop_count;

   always_comb begin
      keep  = 1'b1;
      hi_st = hi;
   end
   assign drop_count = '0;
`endif

   // A full FIFO still takes a request in the cycle the head is popped.
   assign bus.req_ready = (level != LW'(DEPTH)) || pop;
   assign accept        = bus.req_valid && bus.req_ready;
   assign push          = accept && keep && !bus.flush;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      start     = 1'b0;
      done_hit  = 1'b0;
      case (state)
         IDLE: begin
            if (level != '0 && !bus.flush) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            start     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.eng_done) begin
               done_hit  = 1'b1;
               state_nxt = GAP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         eng_x0     <= '0;
         eng_x1     <= '0;
         eng_y      <= '0;
         eng_z      <= '0;
         spans_done <= '0;
      end else begin
         state <= state_nxt;
         if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      level <= level + LW'(1);
            else if (pop && !push) level <= level - LW'(1);
         end
         if (pop) {eng_x0, eng_x1, eng_y, eng_z} <= mem[rd_ptr];
         if (done_hit) spans_done <= spans_done + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {lo, hi_st, bus.req_y, bus.req_z};
   end

   assign bus.eng_start  = start;
   assign bus.eng_x0     = eng_x0;
   assign bus.eng_x1     = eng_x1;
   assign bus.eng_y      = eng_y;
   assign bus.eng_z      = eng_z;
   assign bus.busy       = (level != '0) || (state != IDLE);
   assign bus.level      = level;
   assign bus.spans_done = spans_done;
   assign bus.drop_count = drop_count;
endmodule

`default_nettype wire

// File: tb/tb_span_scheduler.sv
// tb_span_scheduler: directed checks of span_scheduler with a simple span engine model.
// Rev 1.0
`default_nettype none

module tb_span_scheduler;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic model_done = 1'b0;
   logic man_done = 1'b0;
   logic eng_auto = 1'b1;
   int   eng_lat = 12;
   int   cyc = 0;
   int   tests = 0;
   int   errors = 0;
   int   n_start = 0;
   int   max_level = 0;
   int   full_block = 0;
   int   last_push_cyc = 0;
   int   last_push_level = 0;
   logic [43:0] log_q [$];
   int          log_cyc [$];

   span_scheduler_if #(.DEPTH(DEPTH)) bus ();

   span_scheduler #(.DEPTH(DEPTH), .SCREEN_W(640), .SCREEN_H(480)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   assign bus.eng_done = model_done | man_done;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.eng_start) n_start++;
      if (int'(bus.level) > max_level) max_level = int'(bus.level);
      if (bus.level == DEPTH && !bus.req_ready) full_block++;
   end

   // Engine model: logs every start, then answers with done after eng_lat cycles.
   initial begin
      logic [43:0] cap;
      forever begin
         @(negedge clk);
         if (bus.eng_start) begin
            cap = {bus.eng_x0, bus.eng_x1, bus.eng_y, bus.eng_z};
            log_q.push_back(cap);
            log_cyc.push_back(cyc);
            if (eng_auto) begin
               repeat (eng_lat - 1) @(negedge clk);
               check("eng_stable", {bus.eng_x0, bus.eng_x1, bus.eng_y, bus.eng_z}, cap);
               model_done = 1'b1;
               @(negedge clk);
               model_done = 1'b0;
            end
         end
      end
   end

   task automatic push_span(input logic [10:0] x0, x1, y, z);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_x0 = x0;
      bus.req_x1 = x1;
      bus.req_y  = y;
      bus.req_z  = z;
      while (!bus.req_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("push_timeout", 64'(n < 2000), 64'd1);
      last_push_cyc   = cyc;
      last_push_level = int'(bus.level);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (bus.busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(n < 3000), 64'd1);
   endtask

   function automatic logic [43:0] span(input int x0, x1, y, z);
      return {11'(x0), 11'(x1), 11'(y), 11'(z)};
   endfunction

   initial begin
      int base;
      int s0;
      int d0;
      bus.req_valid = 1'b0;
      bus.req_x0 = '0;
      bus.req_x1 = '0;
      bus.req_y  = '0;
      bus.req_z  = '0;
      bus.flush  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_eng_start", 64'(bus.eng_start), 64'd0);
      check("rst_eng_x", {bus.eng_x0, bus.eng_x1, bus.eng_y, bus.eng_z}, 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_level", 64'(bus.level), 64'd0);
      check("rst_spans_done", 64'(bus.spans_done), 64'd0);
      check("rst_drop_count", 64'(bus.drop_count), 64'd0);
      check("rst_req_ready", 64'(bus.req_ready), 64'd1);

      // 1. Single span, latency from push to start is two cycles
      eng_lat = 12;
      push_span(11'd10, 11'd20, 11'd5, 11'd9);
      wait_idle("t1_idle_timeout");
      check("t1_starts", 64'(log_q.size()), 64'd1);
      check("t1_span", 64'(log_q[0]), 64'(span(10, 20, 5, 9)));
      check("t1_latency", 64'(log_cyc[0] - last_push_cyc), 64'd2);
      check("t1_spans_done", 64'(bus.spans_done), 64'd1);
      check("t1_busy", 64'(bus.busy), 64'd0);
      check("t1_pulse_count", 64'(n_start), 64'd1);

      // 2. Reversed span is swapped
      push_span(11'd30, 11'd3, 11'd7, 11'd1);
      wait_idle("t2_idle_timeout");
      check("t2_span", 64'(log_q[log_q.size()-1]), 64'(span(3, 30, 7, 1)));
      check("t2_spans_done", 64'(bus.spans_done), 64'd2);

      // 3. DEPTH+2 back-to-back spans with a slow engine
      eng_lat = 20;
      base = log_q.size();
      max_level = 0;
      full_block = 0;
      for (int i = 0; i < DEPTH + 2; i++)
         push_span(11'(i * 10), 11'(i * 10 + 5), 11'(i), 11'(100 + i));
      check("t3_last_push_at_full", 64'(last_push_level), 64'(DEPTH));
      check("t3_level_kept_full", 64'(bus.level), 64'(DEPTH));
      wait_idle("t3_idle_timeout");
      check("t3_max_level", 64'(max_level), 64'(DEPTH));
      check("t3_ready_low_full", 64'(full_block > 0), 64'd1);
      check("t3_count", 64'(log_q.size() - base), 64'(DEPTH + 2));
      for (int i = 0; i < DEPTH + 2; i++)
         check("t3_order", 64'(log_q[base + i]), 64'(span(i * 10, i * 10 + 5, i, 100 + i)));
      check("t3_spans_done", 64'(bus.spans_done), 64'd12);

      // 4. Flush with one in flight and five queued; a same-cycle push is also lost
      eng_lat = 30;
      base = log_q.size();
      s0 = n_start;
      for (int i = 0; i < 6; i++)
         push_span(11'(200 + i), 11'(210 + i), 11'(20), 11'(i));
      check("t4_level_before", 64'(bus.level), 64'd5);
      bus.flush = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_x0 = 11'd1;
      bus.req_x1 = 11'd2;
      @(negedge clk);
      bus.flush = 1'b0;
      bus.req_valid = 1'b0;
      check("t4_level_after", 64'(bus.level), 64'd0);
      check("t4_busy_in_flight", 64'(bus.busy), 64'd1);
      wait_idle("t4_idle_timeout");
      repeat (10) @(negedge clk);
      check("t4_spans_done", 64'(bus.spans_done), 64'd13);
      check("t4_starts", 64'(n_start - s0), 64'd1);
      check("t4_span", 64'(log_q[base]), 64'(span(200, 210, 20, 0)));
      check("t4_level_end", 64'(bus.level), 64'd0);

`ifdef SPAN_CLIP_EN
      // 5. Clipping to the screen
      eng_lat = 4;
      push_span(11'd600, 11'd700, 11'd10, 11'd3);
      wait_idle("t5_idle_timeout");
      check("t5_clip_x1", 64'(log_q[log_q.size()-1]), 64'(span(600, 639, 10, 3)));
      s0 = n_start;
      push_span(11'd650, 11'd660, 11'd10, 11'd3);
      repeat (4) @(negedge clk);
      check("t5_drop_x", 64'(bus.drop_count), 64'd1);
      push_span(11'd0, 11'd5, 11'd480, 11'd3);
      repeat (4) @(negedge clk);
      check("t5_drop_y", 64'(bus.drop_count), 64'd2);
      check("t5_no_start", 64'(n_start - s0), 64'd0);
      check("t5_level", 64'(bus.level), 64'd0);
`else
      check("t5_drop_tied", 64'(bus.drop_count), 64'd0);
`endif

      // 6. Reset while waiting on the engine, then a stray done
      eng_lat = 6;
      eng_auto = 1'b0;
      s0 = n_start;
      push_span(11'd50, 11'd60, 11'd1, 11'd2);
      d0 = 0;
      while (n_start == s0 && d0 < 100) begin
         @(negedge clk);
         d0++;
      end
      check("t6_start_timeout", 64'(d0 < 100), 64'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t6_rst_eng_x", {bus.eng_x0, bus.eng_x1, bus.eng_y, bus.eng_z}, 64'd0);
      check("t6_rst_flags", {bus.eng_start, bus.busy, bus.level}, 64'd0);
      check("t6_rst_counts", {bus.spans_done, bus.drop_count}, 64'd0);
      check("t6_rst_ready", 64'(bus.req_ready), 64'd1);
      man_done = 1'b1;
      @(negedge clk);
      man_done = 1'b0;
      @(negedge clk);
      check("t6_stray_done", 64'(bus.spans_done), 64'd0);
      check("t6_stray_busy", 64'(bus.busy), 64'd0);
      eng_auto = 1'b1;
      push_span(11'd1, 11'd2, 11'd3, 11'd4);
      wait_idle("t6_idle_timeout");
      check("t6_span", 64'(log_q[log_q.size()-1]), 64'(span(1, 2, 3, 4)));
      check("t6_spans_done", 64'(bus.spans_done), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end
endmodule

`default_nettype wire
